// File: rtl/axil_uart_responder.sv
// axil_uart_responder
//   AXI4-Lite slave exposing the UART-Lite register map (RXFIFO/TXFIFO/STAT/CTRL)
//   on top of two byte FIFOs. The RX FIFO is fed from a byte-stream input and the
//   TX FIFO drains to a byte-stream output. Intended as an emulation/loopback
//   endpoint standing in for a real UART core.
//
//   Optional build macro: AXIL_SLVERR_EN
//     defined   -> writes to RX/STAT, reads of TX/CTRL and dropped TX writes
//                  answer SLVERR (2'b10) with no side effect
//     undefined -> every response is OKAY
//
//   Ports
//     clk, rst             clock, asynchronous active-high reset
//     s_axi_aw* / w* / b*  AXI-Lite write channel (AW and W handshake together)
//     s_axi_ar* / r*       AXI-Lite read channel
//     rx_byte/_valid       push strobe into RX FIFO, no backpressure
//     tx_byte/_valid/_ready TX FIFO head, popped on valid&ready

// Byte FIFO with flush; head reads 0 when empty.
module axil_uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       push_ok,
  output logic       pop_ok
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // flush beats everything; a push into a full FIFO survives only alongside a pop
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign head = empty ? 8'h00 : mem[rd_ptr];
endmodule

module axil_uart_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_byte_valid,
  input  logic              tx_byte_ready
);
  localparam logic [1:0] A_RX = 2'd0, A_TX = 2'd1, A_STAT = 2'd2, A_CTRL = 2'd3;
  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] SLVERR = 2'b10;
`endif

  logic       wr_hs, ar_hs;
  logic [1:0] wr_addr, rd_addr;
  logic       rx_pop, rx_flush, tx_push, tx_pop, tx_flush;
  logic [7:0] rx_head;
  logic       rx_empty, rx_full, rx_push_ok, rx_pop_ok;
  logic       tx_empty, tx_full, tx_push_ok, tx_pop_ok;
  logic       overrun;
  logic [31:0] stat, rd_value;
  logic [1:0] wr_resp, rd_resp;

  assign wr_addr = s_axi_awaddr[3:2];
  assign rd_addr = s_axi_araddr[3:2];

  // handshakes are gated by rst so every output reads 0 while reset is held
  assign wr_hs         = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~rst;
  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign ar_hs         = s_axi_arvalid & ~s_axi_rvalid & ~rst;
  assign s_axi_arready = ar_hs;

  assign rx_pop   = ar_hs & (rd_addr == A_RX);
  assign rx_flush = wr_hs & (wr_addr == A_CTRL) & s_axi_wdata[1];
  assign tx_push  = wr_hs & (wr_addr == A_TX);
  assign tx_flush = wr_hs & (wr_addr == A_CTRL) & s_axi_wdata[0];
  assign tx_pop   = tx_byte_valid & tx_byte_ready;

  axil_uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_byte_valid), .pop(rx_pop), .flush(rx_flush),
    .din(rx_byte), .head(rx_head), .empty(rx_empty), .full(rx_full),
    .push_ok(rx_push_ok), .pop_ok(rx_pop_ok)
  );

  axil_uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(s_axi_wdata[7:0]), .head(tx_byte), .empty(tx_empty), .full(tx_full),
    .push_ok(tx_push_ok), .pop_ok(tx_pop_ok)
  );

  assign tx_byte_valid = ~tx_empty;

  assign stat = {26'b0, overrun, 1'b0, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    rd_value = 32'h0;
    case (rd_addr)
      A_RX:    rd_value = {24'b0, rx_head};
      A_STAT:  rd_value = stat;
      default: rd_value = 32'h0;
    endcase
  end

`ifdef AXIL_SLVERR_EN
  // a TX write is an error only if it is actually dropped (full with no same-cycle pop)
  assign wr_resp = ((wr_addr == A_RX) || (wr_addr == A_STAT) ||
                    ((wr_addr == A_TX) && tx_full && !tx_pop_ok)) ? SLVERR : OKAY;
  assign rd_resp = ((rd_addr == A_TX) || (rd_addr == A_CTRL)) ? SLVERR : OKAY;
`else
  assign wr_resp = OKAY;
  assign rd_resp = OKAY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else if (wr_hs) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_resp;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= 32'h0;
      s_axi_rresp  <= 2'b00;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= (rd_resp == OKAY) ? rd_value : 32'h0;
      s_axi_rresp  <= rd_resp;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // a dropped RX byte (not flushed) sets overrun; set has priority over the STAT-read clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          overrun <= 1'b0;
    else if (rx_byte_valid & ~rx_push_ok & ~rx_flush) overrun <= 1'b1;
    else if (ar_hs && rd_addr == A_STAT)              overrun <= 1'b0;
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_wdata[31:8], s_axi_awaddr, s_axi_araddr,
                       rx_pop_ok, tx_push_ok, tx_pop_ok};
endmodule

// File: tb/tb_axil_uart_responder.sv
module tb_axil_uart_responder;
  localparam int D = 16;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic        clk = 1'b0, rst;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic [7:0]  rx_byte, tx_byte;
  logic        rx_byte_valid, tx_byte_valid, tx_byte_ready;

  always #5 clk = ~clk;

  axil_uart_responder #(.FIFO_DEPTH(D), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready)
  );

  int n_assert = 0, n_fail = 0;

  // reference model: plain queues plus the sticky overrun bit
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    return {26'b0, ovr, 1'b0, tx_q.size() == D, tx_q.size() == 0,
            rx_q.size() == D, rx_q.size() != 0};
  endfunction

  // all tasks start and end on a falling edge
  task automatic do_read(input logic [1:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    araddr = {a, 2'b00}; arvalid = 1'b1; #1;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    check("ar_wait", arready, 1);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_latency", rvalid, 1);
    d = rdata; r = rresp;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] dat, output logic [1:0] r);
    int n = 0;
    awaddr = {a, 2'b00}; wdata = dat; awvalid = 1'b1; wvalid = 1'b1; #1;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    check("aw_wait", awready, 1);
    check("w_with_aw", wready, 1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid", bvalid, 1);
    r = bresp;
    @(negedge clk);
  endtask

  task automatic rd_rx_chk(input string tag);
    logic [31:0] d, e; logic [1:0] r;
    e = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
    do_read(2'd0, d, r);
    check(tag, d, e);
    check("rx_rresp", r, 2'b00);
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [31:0] d, e; logic [1:0] r;
    e = stat_exp(); ovr = 0;
    do_read(2'd2, d, r);
    check(tag, d, e);
    check("stat_rresp", r, 2'b00);
  endtask

  task automatic wr_tx(input logic [7:0] b);
    logic [1:0] r; logic [1:0] e;
    e = 2'b00;
    if (tx_q.size() < D) tx_q.push_back(b); else e = ERR;
    do_write(2'd1, {24'hABCDEF, b}, r);
    check("tx_bresp", r, e);
  endtask

  task automatic wr_ctrl(input logic [1:0] f);
    logic [1:0] r;
    if (f[0]) tx_q.delete();
    if (f[1]) rx_q.delete();
    do_write(2'd3, {30'h0, f}, r);
    check("ctrl_bresp", r, 2'b00);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_byte = b; rx_byte_valid = 1'b1;
    @(negedge clk);
    rx_byte_valid = 1'b0;
    if (rx_q.size() < D) rx_q.push_back(b); else ovr = 1;
  endtask

  task automatic tx_pop_chk(input string tag);
    check({tag, "_valid"}, tx_byte_valid, tx_q.size() != 0);
    check({tag, "_byte"}, tx_byte, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
    tx_byte_ready = 1'b1;
    @(negedge clk);
    tx_byte_ready = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  initial begin
    logic [31:0] d; logic [1:0] r;
    rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; wdata = '0;
    bready = 1'b1; arvalid = 0; rready = 1'b1; rx_byte = '0; rx_byte_valid = 0;
    tx_byte_ready = 0;
    @(negedge clk); @(negedge clk);
    check("rst_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp,
                          tx_byte_valid, tx_byte}, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset STAT
    do_read(2'd2, d, r);
    check("t1_stat", d, 32'h4);
    check("t1_rresp", r, 2'b00);

    // 2: two RX bytes, then an empty read
    push_rx(8'h24); push_rx(8'h47);
    rd_rx_chk("t2_rx0"); rd_rx_chk("t2_rx1"); rd_rx_chk("t2_rx_empty");
    rd_stat_chk("t2_stat");

    // 3: overflow RX by one
    for (int i = 0; i < D; i++) push_rx(8'(8'h30 + i));
    rd_stat_chk("t3_stat_full");
    push_rx(8'hEE);
    do_read(2'd2, d, r);
    check("t3_stat_ovr", d, 32'h27); ovr = 0;
    rd_stat_chk("t3_stat_cleared");
    for (int i = 0; i < D; i++) rd_rx_chk("t3_drain");

    // full RX: push coinciding with a pop is accepted, no overrun
    for (int i = 0; i < D; i++) push_rx(8'(8'h60 + i));
    araddr = 4'h0; arvalid = 1'b1; rx_byte = 8'hA5; rx_byte_valid = 1'b1; #1;
    check("pp_arready", arready, 1);
    @(posedge clk); @(negedge clk);
    arvalid = 0; rx_byte_valid = 0;
    check("pp_rdata", rdata, {24'b0, rx_q.pop_front()});
    rx_q.push_back(8'hA5);
    @(negedge clk);
    rd_stat_chk("pp_stat");
    for (int i = 0; i < D; i++) rd_rx_chk("pp_drain");

    // 4: TX single byte
    wr_tx(8'h55);
    check("t4_byte", tx_byte, 8'h55);
    check("t4_valid", tx_byte_valid, 1);
    tx_pop_chk("t4_pop");
    check("t4_valid_after", tx_byte_valid, 0);
    rd_stat_chk("t4_stat");

    // TX full: extra write dropped
    for (int i = 0; i <= D; i++) wr_tx(8'(8'h80 + i));
    rd_stat_chk("tx_full_stat");
    for (int i = 0; i < D; i++) tx_pop_chk("tx_full_drain");

    // 5: bready held low
    bready = 1'b0;
    awaddr = 4'h4; wdata = 32'h11; awvalid = 1; wvalid = 1; #1;
    check("t5_aw1", awready, 1);
    @(posedge clk); @(negedge clk);
    tx_q.push_back(8'h11);
    wdata = 32'h22;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_bvalid_hold", bvalid, 1);
      check("t5_aw_blocked", awready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk); #1;
    check("t5_bvalid_drop", bvalid, 0);
    check("t5_aw2", awready, 1);
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("t5_b2", bvalid, 1);
    tx_q.push_back(8'h22);
    @(negedge clk);
    tx_pop_chk("t5_pop1"); tx_pop_chk("t5_pop2");

    // 6: error responses
    do_write(2'd2, 32'hFF, r);
    check("t6_bresp_stat", r, ERR);
    do_read(2'd3, d, r);
    check("t6_rdata_ctrl", d, 0);
    check("t6_rresp_ctrl", r, ERR);
    do_read(2'd1, d, r);
    check("t6_rdata_tx", d, 0);
    rd_stat_chk("t6_stat_untouched");

    // flush via CTRL
    push_rx(8'h01); wr_tx(8'h02);
    wr_ctrl(2'b11);
    rd_stat_chk("flush_stat");

    // random mix against the model
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: push_rx(8'($urandom));
        3:       rd_rx_chk("rnd_rx");
        4:       rd_stat_chk("rnd_stat");
        5, 6:    wr_tx(8'($urandom));
        7:       tx_pop_chk("rnd_tx");
        8:       if ($urandom_range(0, 3) == 0) wr_ctrl(2'($urandom)); else rd_rx_chk("rnd_rx2");
        default: begin
          do_read(2'd1, d, r);
          check("rnd_rd_tx", d, 0);
        end
      endcase
    end
    rd_stat_chk("rnd_final_stat");

    // reset in the middle of a read
    wr_tx(8'h9C);
    araddr = 4'h8; arvalid = 1'b1;
    @(posedge clk); #1;
    check("mid_rvalid", rvalid, 1);
    rst = 1'b1; #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_txv", tx_byte_valid, 0);
    arvalid = 0;
    rx_q.delete(); tx_q.delete(); ovr = 0;
    @(negedge clk); rst = 1'b0; @(negedge clk);
    rd_stat_chk("post_rst_stat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
